// File: rtl/imem_fetch_arb.sv
// Instruction-memory arbiter: a boot loader and the core fetch port share one single-port BRAM.
// Latency: grants are combinational; a fetch response appears one cycle after its grant (1/cycle throughput).
// Backpressure: loader wins by default, fetch wins after three consecutive lost cycles; no grant while in reset.
module imem_fetch_arb #(
  parameter  int DWIDTH    = 32,
  parameter  int MEM_SIZE  = 16384,
  localparam int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                 Clk_Core,
  input  logic                 Rst_Core,
  // core fetch port
  input  logic                 Fetch_Req,
  input  logic [DWIDTH-1:0]    Fetch_Addr,
  output logic                 Fetch_Gnt,
  output logic                 Fetch_Valid,
  output logic [31:0]          Fetch_Instr,
  output logic                 Fetch_Err,
  // boot loader port
  input  logic                 Load_Valid,
  output logic                 Load_Ready,
  input  logic [DWIDTH-1:0]    Load_Addr,
  input  logic [31:0]          Load_Data,
  input  logic                 Load_Done,
  output logic                 Boot_Done,
  // single-port BRAM
  output logic                 Mem_En,
  output logic                 Mem_We,
  output logic [ADDR_SIZE-1:0] Mem_Addr,
  output logic [31:0]          Mem_Wdata,
  input  logic [31:0]          Mem_Rdata
);

  // Returned for faulting fetches and shown after reset: RISC-V "addi x0,x0,0".
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q;
  logic                  boot_done_q;
  logic [1:0]            starve_q, starve_d;
  logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  rsp_vld_q;
  logic                  rsp_err_q;
  logic [31:0]           instr_q;

  logic                  in_run;
  logic [DWIDTH-1:0]     load_hi;
  logic [DWIDTH-1:0]     fetch_hi;
  logic                  load_ok;
  logic                  fetch_ok;
  logic                  fetch_wins;
  logic                  load_gnt;
  logic                  fetch_gnt;

  assign in_run = (state_q == ST_RUN);

  // Address legality: word aligned and inside the BRAM (no bits above the word index).
  assign load_hi  = Load_Addr  >> (ADDR_SIZE + 2);
  assign fetch_hi = Fetch_Addr >> (ADDR_SIZE + 2);
  assign load_ok  = (Load_Addr[1:0]  == 2'b00) && (load_hi  == '0);
  assign fetch_ok = (Fetch_Addr[1:0] == 2'b00) && (fetch_hi == '0);

  // Fetch only competes in RUN; it beats a pending load once it has starved three cycles.
  // Grants are suppressed while reset is asserted so nothing is accepted into a resetting block.
  assign fetch_wins = in_run && Fetch_Req && (!Load_Valid || (starve_q == 2'd3));
  assign fetch_gnt  = !Rst_Core && fetch_wins;
  assign load_gnt   = !Rst_Core && Load_Valid && !fetch_wins;

  assign Fetch_Gnt  = fetch_gnt;
  assign Load_Ready = load_gnt;

  // BRAM port steering: legal load writes, legal fetch reads, otherwise address/data hold.
  always_comb begin
    Mem_En      = 1'b0;
    Mem_We      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (load_gnt && load_ok) begin
      Mem_En      = 1'b1;
      Mem_We      = 1'b1;
      mem_addr_d  = Load_Addr[ADDR_SIZE+1:2];
      mem_wdata_d = Load_Data;
    end else if (fetch_gnt && fetch_ok) begin
      Mem_En      = 1'b1;
      mem_addr_d  = Fetch_Addr[ADDR_SIZE+1:2];
    end
  end

  assign Mem_Addr  = mem_addr_d;
  assign Mem_Wdata = mem_wdata_d;

  // Starvation counter: counts cycles a requesting fetch loses to the loader, saturating at 3.
  always_comb begin
    starve_d = starve_q;
    if (!in_run || !Fetch_Req || fetch_gnt) begin
      starve_d = 2'd0;
    end else if (load_gnt && (starve_q != 2'd3)) begin
      starve_d = starve_q + 2'd1;
    end
  end

  // Arbitration history and held BRAM address/data registers.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      starve_q    <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Boot/run state machine: leaves BOOT on Load_Done and stays in RUN until reset.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state_q     <= ST_BOOT;
      boot_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (Load_Done) begin
            state_q     <= ST_RUN;
            boot_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          boot_done_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_BOOT;
          boot_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign Boot_Done = boot_done_q;

  // Fetch response tracking: one valid pulse per grant; an error grant never touched the BRAM.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_vld_q <= fetch_gnt;
      rsp_err_q <= fetch_gnt && !fetch_ok;
    end
  end

  // Remember the last delivered instruction so the output holds between responses.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      instr_q <= NOP_INSTR;
    end else if (rsp_vld_q) begin
      instr_q <= Fetch_Instr;
    end
  end

  // BRAM data arrives in the response cycle, so it is forwarded directly while valid.
  always_comb begin
    Fetch_Instr = instr_q;
    if (rsp_vld_q) begin
      Fetch_Instr = rsp_err_q ? NOP_INSTR : Mem_Rdata;
    end
  end

  assign Fetch_Valid = rsp_vld_q;
  assign Fetch_Err   = rsp_err_q;

endmodule

// File: tb/tb_imem_fetch_arb.sv
// Bench for imem_fetch_arb: per-cycle vector table with a fetch-response scoreboard,
// a behavioural BRAM, and hand-written reset sequences.
module tb_imem_fetch_arb;

  localparam int DW = 32;
  localparam int MS = 16384;
  localparam int AS = 14;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          Clk_Core = 1'b0;
  logic          Rst_Core;
  logic          Fetch_Req;
  logic [DW-1:0] Fetch_Addr;
  logic          Fetch_Gnt;
  logic          Fetch_Valid;
  logic [31:0]   Fetch_Instr;
  logic          Fetch_Err;
  logic          Load_Valid;
  logic          Load_Ready;
  logic [DW-1:0] Load_Addr;
  logic [31:0]   Load_Data;
  logic          Load_Done;
  logic          Boot_Done;
  logic          Mem_En;
  logic          Mem_We;
  logic [AS-1:0] Mem_Addr;
  logic [31:0]   Mem_Wdata;
  logic [31:0]   Mem_Rdata = 32'h0;

  imem_fetch_arb #(.DWIDTH(DW), .MEM_SIZE(MS)) dut (
    .Clk_Core    (Clk_Core),
    .Rst_Core    (Rst_Core),
    .Fetch_Req   (Fetch_Req),
    .Fetch_Addr  (Fetch_Addr),
    .Fetch_Gnt   (Fetch_Gnt),
    .Fetch_Valid (Fetch_Valid),
    .Fetch_Instr (Fetch_Instr),
    .Fetch_Err   (Fetch_Err),
    .Load_Valid  (Load_Valid),
    .Load_Ready  (Load_Ready),
    .Load_Addr   (Load_Addr),
    .Load_Data   (Load_Data),
    .Load_Done   (Load_Done),
    .Boot_Done   (Boot_Done),
    .Mem_En      (Mem_En),
    .Mem_We      (Mem_We),
    .Mem_Addr    (Mem_Addr),
    .Mem_Wdata   (Mem_Wdata),
    .Mem_Rdata   (Mem_Rdata)
  );

  always #5 Clk_Core = ~Clk_Core;

  // Behavioural single-port BRAM with one-cycle read latency.
  logic [31:0] bram [0:MS-1];
  always @(posedge Clk_Core) begin
    if (Mem_En) begin
      if (Mem_We) bram[Mem_Addr] <= Mem_Wdata;
      else        Mem_Rdata      <= bram[Mem_Addr];
    end
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        lv;
    logic [31:0] la;
    logic [31:0] ld;
    logic        done;
    logic        fr;
    logic [31:0] fa;
    logic        lrdy;
    logic        fgnt;
    logic        en;
    logic        we;
    logic [13:0] addr;
    logic        boot;
    logic        xerr;
    logic [31:0] xinstr;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] instr;
  } rsp_t;

  vec_t        vecs[$];
  rsp_t        sb[$];
  logic [31:0] last_instr = NOP;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic lv, input logic [31:0] la, input logic [31:0] ld,
                              input logic done, input logic fr, input logic [31:0] fa,
                              input logic lrdy, input logic fgnt, input logic en, input logic we,
                              input logic [13:0] addr, input logic boot,
                              input logic xerr, input logic [31:0] xinstr);
    vec_t v;
    v.lv = lv; v.la = la; v.ld = ld; v.done = done; v.fr = fr; v.fa = fa;
    v.lrdy = lrdy; v.fgnt = fgnt; v.en = en; v.we = we; v.addr = addr; v.boot = boot;
    v.xerr = xerr; v.xinstr = xinstr;
    return v;
  endfunction

  // Drive one cycle: check the previous cycle's response, then this cycle's combinational outputs.
  task automatic apply(input vec_t v, input int idx, output logic fg);
    rsp_t r;
    Load_Valid = v.lv; Load_Addr = v.la; Load_Data = v.ld; Load_Done = v.done;
    Fetch_Req  = v.fr; Fetch_Addr = v.fa;
    @(negedge Clk_Core);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check($sformatf("r%0d fetch_valid", idx), {31'b0, Fetch_Valid}, 32'd1);
      check($sformatf("r%0d fetch_err", idx), {31'b0, Fetch_Err}, {31'b0, r.err});
      check($sformatf("r%0d fetch_instr", idx), Fetch_Instr, r.instr);
      last_instr = r.instr;
    end else begin
      check($sformatf("r%0d fetch_valid idle", idx), {31'b0, Fetch_Valid}, 32'd0);
      check($sformatf("r%0d fetch_err idle", idx), {31'b0, Fetch_Err}, 32'd0);
      check($sformatf("r%0d fetch_instr hold", idx), Fetch_Instr, last_instr);
    end
    check($sformatf("r%0d load_ready", idx), {31'b0, Load_Ready}, {31'b0, v.lrdy});
    check($sformatf("r%0d fetch_gnt", idx), {31'b0, Fetch_Gnt}, {31'b0, v.fgnt});
    check($sformatf("r%0d mem_en", idx), {31'b0, Mem_En}, {31'b0, v.en});
    check($sformatf("r%0d mem_we", idx), {31'b0, Mem_We}, {31'b0, v.we});
    check($sformatf("r%0d mem_addr", idx), {18'b0, Mem_Addr}, {18'b0, v.addr});
    check($sformatf("r%0d boot_done", idx), {31'b0, Boot_Done}, {31'b0, v.boot});
    if (v.we) check($sformatf("r%0d mem_wdata", idx), Mem_Wdata, v.ld);
    fg = Fetch_Gnt;
    if (v.fgnt) begin
      r.err = v.xerr; r.instr = v.xinstr;
      sb.push_back(r);
    end
    @(posedge Clk_Core); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fg;
    int   fg_cnt;

    //   lv  la          ld            done fr  fa        | lrdy fgnt en we addr boot | xerr xinstr
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 1, 32'h8,     0, 0, 0, 0, 14'd0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h8,     32'h00C00513, 0, 1, 32'h8,     1, 0, 1, 1, 14'd2, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'hC,     32'h11111111, 0, 0, 32'h0,     1, 0, 1, 1, 14'd3, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h12,    32'hDEADBEEF, 0, 0, 32'h0,     1, 0, 0, 0, 14'd3, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h10008, 32'hDEADBEEF, 0, 0, 32'h0,     1, 0, 0, 0, 14'd3, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h10,    32'h22222222, 1, 1, 32'h8,     1, 0, 1, 1, 14'd4, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 1, 32'h8,     0, 1, 1, 0, 14'd2, 1, 0, 32'h00C00513));
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 1, 32'hC,     0, 1, 1, 0, 14'd3, 1, 0, 32'h11111111));
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 1, 32'h6,     0, 1, 0, 0, 14'd3, 1, 1, NOP));
    vecs.push_back(mk(0, 32'h0,     32'h0,        1, 1, 32'h10,    0, 1, 1, 0, 14'd4, 1, 0, 32'h22222222));
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 1, 32'h20010, 0, 1, 0, 0, 14'd4, 1, 1, NOP));
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 0, 32'h0,     0, 0, 0, 0, 14'd4, 1, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 0, 32'h0,     0, 0, 0, 0, 14'd4, 1, 0, 32'h0));
    // rows 13..20: loader and fetch both requesting -> L,L,L,F repeating
    for (int k = 0; k < 8; k++) begin
      if ((k % 4) == 3)
        vecs.push_back(mk(1, 32'h14, 32'h33333333, 0, 1, 32'h8, 0, 1, 1, 0, 14'd2, 1, 0, 32'h00C00513));
      else
        vecs.push_back(mk(1, 32'h14, 32'h33333333, 0, 1, 32'h8, 1, 0, 1, 1, 14'd5, 1, 0, 32'h0));
    end
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 1, 32'h14,    0, 1, 1, 0, 14'd5, 1, 0, 32'h33333333));
    // a dropped fetch request clears the starvation count
    vecs.push_back(mk(1, 32'h18,    32'h44444444, 0, 1, 32'h14,    1, 0, 1, 1, 14'd6, 1, 0, 32'h0));
    vecs.push_back(mk(1, 32'h18,    32'h44444444, 0, 0, 32'h14,    1, 0, 1, 1, 14'd6, 1, 0, 32'h0));
    vecs.push_back(mk(1, 32'h18,    32'h44444444, 0, 1, 32'h14,    1, 0, 1, 1, 14'd6, 1, 0, 32'h0));
    vecs.push_back(mk(1, 32'h18,    32'h44444444, 0, 1, 32'h14,    1, 0, 1, 1, 14'd6, 1, 0, 32'h0));
    vecs.push_back(mk(1, 32'h18,    32'h44444444, 0, 1, 32'h14,    1, 0, 1, 1, 14'd6, 1, 0, 32'h0));
    vecs.push_back(mk(1, 32'h18,    32'h44444444, 0, 1, 32'h14,    0, 1, 1, 0, 14'd5, 1, 0, 32'h33333333));
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 1, 32'h18,    0, 1, 1, 0, 14'd6, 1, 0, 32'h44444444));
    vecs.push_back(mk(0, 32'h0,     32'h0,        0, 0, 32'h0,     0, 0, 0, 0, 14'd6, 1, 0, 32'h0));

    // Reset values
    Rst_Core = 1'b1;
    Load_Valid = 1'b0; Load_Addr = '0; Load_Data = '0; Load_Done = 1'b0;
    Fetch_Req = 1'b0; Fetch_Addr = '0;
    repeat (2) @(posedge Clk_Core);
    #2;
    check("reset boot_done", {31'b0, Boot_Done}, 32'd0);
    check("reset fetch_valid", {31'b0, Fetch_Valid}, 32'd0);
    check("reset fetch_err", {31'b0, Fetch_Err}, 32'd0);
    check("reset fetch_instr", Fetch_Instr, NOP);
    check("reset mem_en", {31'b0, Mem_En}, 32'd0);
    check("reset mem_we", {31'b0, Mem_We}, 32'd0);
    check("reset mem_addr", {18'b0, Mem_Addr}, 32'd0);
    check("reset mem_wdata", Mem_Wdata, 32'd0);
    @(posedge Clk_Core); #1;
    Rst_Core = 1'b0;

    // Table-driven run
    fg_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i, fg);
      if (i >= 13 && i <= 20) fg_cnt += int'(fg);
    end
    check("contention fetch grant count", fg_cnt, 32'd2);
    check("scoreboard drained", sb.size(), 32'd0);

    // Reset the cycle after a fetch grant: response discarded, back in BOOT
    Load_Valid = 1'b0; Load_Done = 1'b0; Fetch_Req = 1'b1; Fetch_Addr = 32'h8;
    @(negedge Clk_Core);
    check("pre-reset fetch_gnt", {31'b0, Fetch_Gnt}, 32'd1);
    @(posedge Clk_Core); #1;
    Rst_Core = 1'b1; Fetch_Req = 1'b0;
    #1;
    check("async reset fetch_valid", {31'b0, Fetch_Valid}, 32'd0);
    check("async reset boot_done", {31'b0, Boot_Done}, 32'd0);
    check("async reset fetch_instr", Fetch_Instr, NOP);
    check("async reset mem_addr", {18'b0, Mem_Addr}, 32'd0);
    repeat (2) @(posedge Clk_Core);
    #1;
    Rst_Core = 1'b0; Fetch_Req = 1'b1; Fetch_Addr = 32'h8;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk_Core);
      check($sformatf("post-reset c%0d fetch_valid", c), {31'b0, Fetch_Valid}, 32'd0);
      check($sformatf("post-reset c%0d boot_done", c), {31'b0, Boot_Done}, 32'd0);
      check($sformatf("post-reset c%0d fetch_gnt", c), {31'b0, Fetch_Gnt}, 32'd0);
      @(posedge Clk_Core); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arb.md
IMEM_FETCH_ARB -- requirements
Module: imem_fetch_arb

Interface
REQ-001 Parameter DWIDTH, 32, width of fetch and load byte addresses.
REQ-002 Parameter MEM_SIZE, 16384, instruction memory depth in 32-bit words; ADDR_SIZE = clog2(MEM_SIZE).
REQ-003 Clk_Core  in  1  core clock; all state SHALL update on its rising edge.
REQ-004 Rst_Core  in  1  reset, asynchronous, active-high.
REQ-005 Fetch_Req  in  1  core fetch request.
REQ-006 Fetch_Addr  in  DWIDTH  fetch byte address (PC).
REQ-007 Fetch_Gnt  out  1  fetch request accepted this cycle.
REQ-008 Fetch_Valid  out  1  Fetch_Instr holds the response to the previous cycle's grant.
REQ-009 Fetch_Instr  out  32  fetched instruction.
REQ-010 Fetch_Err  out  1  qualifies Fetch_Valid: misaligned or out-of-range fetch.
REQ-011 Load_Valid  in  1  loader write request.
REQ-012 Load_Ready  out  1  loader write accepted this cycle.
REQ-013 Load_Addr  in  DWIDTH  loader byte address.
REQ-014 Load_Data  in  32  loader write data.
REQ-015 Load_Done  in  1  loader finished the image.
REQ-016 Boot_Done  out  1  block is in RUN.
REQ-017 Mem_En, Mem_We  out  1 each  single-port BRAM enable and write enable.
REQ-018 Mem_Addr  out  ADDR_SIZE  BRAM word address.
REQ-019 Mem_Wdata  out  32  BRAM write data.
REQ-020 Mem_Rdata  in  32  BRAM read data, valid the cycle after a read enable.

Function
REQ-021 States BOOT and RUN only; reset SHALL enter BOOT.
REQ-022 BOOT -> RUN when Load_Done=1; RUN SHALL persist until reset, Load_Done in RUN ignored.
REQ-023 BOOT: Fetch_Gnt=0; Load_Ready=Load_Valid.
REQ-024 Load_Valid and Load_Done in the same BOOT cycle: write performed, then RUN next cycle.
REQ-025 RUN: one BRAM access per cycle; loader has priority over fetch, except fetch SHALL win when a 2-bit starvation counter equals 3.
REQ-026 Starvation counter increments on each cycle where fetch is requested and the loader wins, saturates at 3, clears on any fetch grant or when Fetch_Req=0.
REQ-027 Loader grant: Mem_En=1, Mem_We=1, Mem_Addr=Load_Addr[ADDR_SIZE+1:2], Mem_Wdata=Load_Data.
REQ-028 Loader address misaligned or out of range (any bit of Load_Addr[DWIDTH-1:ADDR_SIZE+2] set): Load_Ready=1, write dropped (Mem_We=0).
REQ-029 Fetch grant with legal address: Mem_En=1, Mem_We=0, Mem_Addr=Fetch_Addr[ADDR_SIZE+1:2]; next cycle Fetch_Valid=1, Fetch_Err=0, Fetch_Instr=Mem_Rdata.
REQ-030 Fetch grant with Fetch_Addr[1:0]!=0 or out of range: no BRAM access; next cycle Fetch_Valid=1, Fetch_Err=1, Fetch_Instr=32'h00000013.
REQ-031 Fetch_Valid SHALL be a single-cycle pulse per grant; back-to-back grants SHALL yield back-to-back valids (throughput 1/cycle).
REQ-032 Fetch_Instr SHALL hold its last delivered value while Fetch_Valid=0.
REQ-033 No grant: Mem_En=0, Mem_We=0, Mem_Addr and Mem_Wdata hold previous values.
REQ-034 Fetch_Gnt and Load_Ready are combinational from requests and state; never both 1 in one cycle.

Reset
REQ-035 Rst_Core=1 SHALL asynchronously force: state BOOT, Boot_Done=0, Fetch_Valid=0, Fetch_Err=0, Fetch_Instr=32'h00000013, starvation counter 0, Mem_En=0, Mem_We=0, Mem_Addr=0, Mem_Wdata=0.
REQ-036 Reset during an outstanding fetch SHALL discard it; no Fetch_Valid after reset release without a new grant.

Verification
REQ-037 BOOT, Load_Valid with Load_Addr=0x8, Load_Data=0x00C00513, Fetch_Req=1 -> Load_Ready=1, Mem_We=1, Mem_Addr=2, Fetch_Gnt=0.
REQ-038 RUN, Fetch_Addr=0x8, BRAM word 2 = 0x00C00513 -> next cycle Fetch_Valid=1, Fetch_Err=0, Fetch_Instr=0x00C00513.
REQ-039 RUN, Fetch_Addr=0x6 -> Fetch_Gnt=1, Mem_En=0; next cycle Fetch_Valid=1, Fetch_Err=1, Fetch_Instr=0x00000013.
REQ-040 RUN, Load_Valid and Fetch_Req held high 8 cycles -> grant pattern L,L,L,F repeating; exactly 2 fetch grants.
REQ-041 Load_Valid+Load_Done same cycle -> write performed, Boot_Done=1 next cycle; later Load_Done pulse leaves Boot_Done=1.
REQ-042 Rst_Core asserted the cycle after a fetch grant -> Fetch_Valid=0 immediately and after release, state BOOT, Boot_Done=0.
